kamacore_pipeline_chain: RTL and testbench

Parametrised chain of pipeline registers that replaces the fixed, global-hold-only stage registers between kamacore stages. Each of `STAGES` slots carries a `WIDTH`-bit payload with per-slot valid, valid/ready backpressure, an optional skid buffer per slot, per-slot kill for branch/exception flushes, and occupancy reporting for hazard logic. It sits between any producer/consumer stage pair, e.g. IF→ID→EX, with one instance per pipeline segment.

---
 rtl/kamacore_pipeline_chain.sv | 75 +++++++
 tb/tb_kamacore_pipeline_chain.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/kamacore_pipeline_chain.sv
// kamacore_pipeline_chain: valid/ready pipeline register chain with optional skid entries, per-slot kill and occupancy
module kamacore_pipeline_chain #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int SKID   = 1,
  parameter int CNT_W  = $clog2(STAGES * (1 + SKID) + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic [STAGES-1:0] kill,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [STAGES-1:0] slot_valid,
  output logic [CNT_W-1:0]  occupancy
);
  logic [STAGES-1:0] main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic [WIDTH-1:0]  main_q [STAGES];
  logic [WIDTH-1:0]  skid_q [STAGES];
  logic [WIDTH-1:0]  up_d [STAGES];
  logic [STAGES:0]   rdy, go;
  logic              acc;
  logic [CNT_W-1:0]  occ_q, occ_d;
  // per-slot ready and transfer strobes; go[i] moves a word into slot i, go[STAGES] is the output handshake
  always_comb begin
    rdy = '0;
    go  = '0;
    rdy[STAGES] = out_ready;
    for (int i = 0; i < STAGES; i++)
      rdy[i] = SKID != 0 ? !skid_v_q[i] : out_ready || |(~main_v_q >> i);
    acc   = !hold && rdy[0];
    go[0] = in_valid && acc;
    for (int i = 1; i <= STAGES; i++) go[i] = main_v_q[i-1] && rdy[i] && !hold;
    up_d[0] = in_data;
    for (int i = 1; i < STAGES; i++) up_d[i] = main_q[i-1];
  end
  // next valids: main refills from skid first, then from upstream; kill wins over everything
  always_comb begin
    main_v_d = '0;
    skid_v_d = '0;
    for (int i = 0; i < STAGES; i++) begin
      main_v_d[i] = !kill[i] && ((!main_v_q[i] || go[i+1]) ? (skid_v_q[i] || go[i]) : 1'b1);
      skid_v_d[i] = SKID != 0 && !kill[i] && main_v_q[i] && !go[i+1] && (skid_v_q[i] || go[i]);
    end
    occ_d = CNT_W'($countones({main_v_d, skid_v_d}));
  end
  // valid and occupancy state, discarded asynchronously on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_v_q <= '0;
      skid_v_q <= '0;
      occ_q    <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      occ_q    <= occ_d;
    end
  end
  // payload registers load only when a word actually moves in, never reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < STAGES; i++) begin
      if ((!main_v_q[i] || go[i+1]) && (skid_v_q[i] || go[i])) main_q[i] <= skid_v_q[i] ? skid_q[i] : up_d[i];
      if (main_v_q[i] && !go[i+1] && go[i]) skid_q[i] <= up_d[i];
    end
  end
  assign in_ready   = rst && acc;
  assign out_valid  = main_v_q[STAGES-1] && !hold;
  assign out_data   = main_q[STAGES-1];
  assign slot_valid = main_v_q | skid_v_q;
  assign occupancy  = occ_q;
endmodule

// File: tb/tb_kamacore_pipeline_chain.sv
// tb_kamacore_pipeline_chain: directed checks of a skid and a non-skid chain instance
module tb_kamacore_pipeline_chain;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hold_s, in_valid_s, in_ready_s, out_valid_s, out_ready_s;
  logic [3:0]  kill_s, slot_valid_s, occ_s;
  logic [31:0] in_data_s, out_data_s;
  logic        hold_f, in_valid_f, in_ready_f, out_valid_f, out_ready_f;
  logic [3:0]  kill_f, slot_valid_f;
  logic [2:0]  occ_f;
  logic [31:0] in_data_f, out_data_f;
  int          n_checks = 0, n_errors = 0;
  int          first_acc, first_out, last_out, peak, n_acc, n;
  logic [31:0] got[$];

  kamacore_pipeline_chain #(.WIDTH(32), .STAGES(4), .SKID(1)) u_skid (
    .clk(clk), .rst(rst), .hold(hold_s), .kill(kill_s),
    .in_valid(in_valid_s), .in_ready(in_ready_s), .in_data(in_data_s),
    .out_valid(out_valid_s), .out_ready(out_ready_s), .out_data(out_data_s),
    .slot_valid(slot_valid_s), .occupancy(occ_s)
  );

  kamacore_pipeline_chain #(.WIDTH(32), .STAGES(4), .SKID(0)) u_flat (
    .clk(clk), .rst(rst), .hold(hold_f), .kill(kill_f),
    .in_valid(in_valid_f), .in_ready(in_ready_f), .in_data(in_data_f),
    .out_valid(out_valid_f), .out_ready(out_ready_f), .out_data(out_data_f),
    .slot_valid(slot_valid_f), .occupancy(occ_f)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_s(input int nw, input logic [31:0] base, input int cycles, input int hold_at);
    n_acc = 0;
    first_acc = -1;
    first_out = -1;
    last_out = -1;
    peak = 0;
    got.delete();
    for (int c = 0; c < cycles; c++) begin
      hold_s = c >= hold_at && c < hold_at + 3;
      in_valid_s = n_acc < nw;
      in_data_s = base + 32'(n_acc) + 32'd1;
      #1;
      if (hold_s) begin
        check("hold_in_ready", in_ready_s, 0);
        check("hold_out_valid", out_valid_s, 0);
        check("hold_slot_valid", slot_valid_s, 4'hF);
      end
      if (in_valid_s && in_ready_s) begin
        if (first_acc < 0) first_acc = c;
        n_acc++;
      end
      if (out_valid_s && out_ready_s) begin
        if (first_out < 0) first_out = c;
        last_out = c;
        got.push_back(out_data_s);
      end
      if (int'(occ_s) > peak) peak = int'(occ_s);
      step();
    end
    hold_s = 1'b0;
    in_valid_s = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    hold_s = 0; kill_s = 0; in_valid_s = 0; in_data_s = 0; out_ready_s = 0;
    hold_f = 0; kill_f = 0; in_valid_f = 0; in_data_f = 0; out_ready_f = 0;
    step();
    #1;
    check("rst_in_ready", in_ready_s, 0);
    check("rst_out_valid", out_valid_s, 0);
    check("rst_slot_valid", slot_valid_s, 0);
    check("rst_occ", occ_s, 0);
    check("rst_in_ready_flat", in_ready_f, 0);
    rst = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready_s, 1);
    check("post_rst_in_ready_flat", in_ready_f, 1);
    step();

    out_ready_s = 1;
    run_s(16, 0, 24, -10);
    check("stream_latency", first_out - first_acc, 4);
    check("stream_count", got.size(), 16);
    check("stream_back_to_back", last_out - first_out, 15);
    check("stream_peak_occ", peak, 4);
    for (int i = 0; i < 16; i++) check("stream_data", got[i], 32'(i + 1));

    out_ready_s = 0;
    run_s(10, 32'hA0, 16, -10);
    check("bp_accepted", n_acc, 8);
    check("bp_in_ready", in_ready_s, 0);
    check("bp_occ", occ_s, 8);
    check("bp_slot_valid", slot_valid_s, 4'hF);
    out_ready_s = 1;
    run_s(2, 32'hA8, 20, -10);
    check("bp_rest_accepted", n_acc, 2);
    check("bp_out_count", got.size(), 10);
    for (int i = 0; i < 10; i++) check("bp_data", got[i], 32'hA1 + 32'(i));

    n = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid_f = n < 4;
      in_data_f = 32'h11 + 32'(n);
      #1;
      if (in_valid_f && in_ready_f) n++;
      step();
    end
    check("flat_fill", n, 4);
    in_valid_f = 1;
    in_data_f = 32'h15;
    #1;
    check("flat_full_in_ready", in_ready_f, 0);
    check("flat_full_occ", occ_f, 4);
    out_ready_f = 1;
    #1;
    check("flat_collapse_ready", in_ready_f, 1);
    check("flat_out_valid", out_valid_f, 1);
    check("flat_out_data", out_data_f, 32'h11);
    step();
    out_ready_f = 0;
    in_valid_f = 0;
    #1;
    check("flat_swap_occ", occ_f, 4);
    check("flat_next_data", out_data_f, 32'h12);

    kill_f = 4'b0011;
    step();
    kill_f = 4'b0000;
    #1;
    check("kill_occ", occ_f, 2);
    check("kill_slot_valid", slot_valid_f, 4'b1100);
    out_ready_f = 1;
    got.delete();
    for (int c = 0; c < 8; c++) begin
      #1;
      if (out_valid_f) got.push_back(out_data_f);
      step();
    end
    out_ready_f = 0;
    check("kill_out_count", got.size(), 2);
    check("kill_out_0", got[0], 32'h12);
    check("kill_out_1", got[1], 32'h13);

    out_ready_s = 1;
    run_s(12, 32'h30, 30, 6);
    check("hold_accepted", n_acc, 12);
    check("hold_out_count", got.size(), 12);
    for (int i = 0; i < 12; i++) check("hold_data", got[i], 32'h31 + 32'(i));

    out_ready_s = 0;
    run_s(2, 32'h50, 8, -10);
    check("hk_slot_valid", slot_valid_s, 4'b1000);
    check("hk_occ", occ_s, 2);
    hold_s = 1;
    kill_s = 4'b1000;
    step();
    kill_s = 4'b0000;
    #1;
    check("hk_killed_slot_valid", slot_valid_s, 0);
    check("hk_killed_occ", occ_s, 0);
    hold_s = 0;
    step();

    run_s(5, 32'h60, 10, -10);
    check("ar_occ_before", occ_s, 5);
    check("ar_out_valid_before", out_valid_s, 1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_out_valid", out_valid_s, 0);
    check("ar_slot_valid", slot_valid_s, 0);
    check("ar_occ", occ_s, 0);
    check("ar_in_ready", in_ready_s, 0);
    step();
    step();
    #2;
    rst = 1'b1;
    step();
    out_ready_s = 1;
    run_s(1, 32'h70, 8, -10);
    check("ar_new_latency", first_out - first_acc, 4);
    check("ar_new_count", got.size(), 1);
    check("ar_new_data", got[0], 32'h71);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
